fwnoc_router_ingress_xy: RTL and testbench

Parametrised ingress manager for one fwnoc router input. It buffers incoming words in an optional internal FIFO and decodes the destination from the header word in the same cycle the header is presented. It forwards the header plus its payload to exactly one of five egress ports: host, N, S, E, W. This version adds configurable data and coordinate widths, XY or YX dimension-order routing, zero-bubble header decode, and drop-with-error for illegal size codes.

---
 rtl/fwnoc_router_ingress_xy.sv | 218 +++++++++++++++++++++
 tb/tb_fwnoc_router_ingress_xy.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwnoc_router_ingress_xy.sv
// fwnoc router ingress manager: input FIFO, header decode,
// XY/YX dimension-order routing and packet forwarding to five egress ports.
module fwnoc_router_ingress_xy #(
    parameter int DAT_WIDTH   = 32,
    parameter int COORD_W     = 2,
    parameter int X_ID        = 0,
    parameter int Y_ID        = 0,
    parameter int FIFO_DEPTH  = 4,
    parameter int ROUTE_YX    = 0,
    parameter int MAX_SZ_CODE = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [DAT_WIDTH-1:0] i_dat,
    output logic [4:0]           e_valid,
    input  logic [4:0]           e_ready,
    output logic [DAT_WIDTH-1:0] e_dat,
    output logic                 busy,
    output logic                 pkt_done,
    output logic                 drop_err
);

    localparam int CW = MAX_SZ_CODE;
    localparam logic [COORD_W-1:0] XC = COORD_W'(X_ID);
    localparam logic [COORD_W-1:0] YC = COORD_W'(Y_ID);
    localparam logic [3:0] MAXC = 4'(MAX_SZ_CODE);

    localparam logic [4:0] P_HOST = 5'b00001;
    localparam logic [4:0] P_N    = 5'b00010;
    localparam logic [4:0] P_S    = 5'b00100;
    localparam logic [4:0] P_E    = 5'b01000;
    localparam logic [4:0] P_W    = 5'b10000;

    typedef enum logic {
        IDLE,
        FWD
    } state_t;

    logic                 h_valid;
    logic [DAT_WIDTH-1:0] h_dat;
    logic                 pop;

    generate
        if (FIFO_DEPTH == 0) begin : g_pass
            // No buffering: the ingress word is the head word and is
            // accepted exactly when the forwarding logic consumes it.
            assign h_valid = i_valid & reset;
            assign h_dat   = i_dat;
            assign i_ready = pop;
        end else begin : g_fifo
            localparam int AW = $clog2(FIFO_DEPTH);

            logic [DAT_WIDTH-1:0] mem [FIFO_DEPTH];
            logic [AW-1:0]        wptr;
            logic [AW-1:0]        rptr;
            logic [AW:0]          count;
            logic                 full;
            logic                 push;

            // A full FIFO refuses pushes even if the head pops this cycle,
            // which keeps i_ready independent of egress readiness.
            assign full    = (count == (AW+1)'(FIFO_DEPTH));
            assign i_ready = ~full & reset;
            assign push    = i_valid & i_ready;
            assign h_valid = (count != '0) & reset;
            assign h_dat   = mem[rptr];

            // Storage array, written on accepted ingress words.
            always_ff @(posedge clock) begin
                if (push) begin
                    mem[wptr] <= i_dat;
                end
            end

            // Pointer and occupancy bookkeeping.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    wptr  <= '0;
                    rptr  <= '0;
                    count <= '0;
                end else begin
                    if (push) begin
                        wptr <= wptr + AW'(1);
                    end
                    if (pop) begin
                        rptr <= rptr + AW'(1);
                    end
                    count <= count + {AW'(0), push} - {AW'(0), pop};
                end
            end
        end
    endgenerate

    logic [COORD_W-1:0] dst_x;
    logic [COORD_W-1:0] dst_y;
    logic [3:0]         code;
    logic               legal;
    logic [CW-1:0]      cnt_load;
    logic [4:0]         route;

    assign dst_x = h_dat[DAT_WIDTH-1 -: COORD_W];
    assign dst_y = h_dat[DAT_WIDTH-1-COORD_W -: COORD_W];
    assign code  = h_dat[3:0];
    assign legal = (code <= MAXC);

    // Payload length: code c selects 2^(c-1) words, code 0 none.
    always_comb begin
        cnt_load = '0;
        if (legal && code != 4'd0) begin
            cnt_load = CW'(1) << (code - 4'd1);
        end
    end

    // Dimension-order route decode of the head word.
    always_comb begin
        route = P_HOST;
        if (ROUTE_YX == 0) begin
            if (dst_x > XC) begin
                route = P_E;
            end else if (dst_x < XC) begin
                route = P_W;
            end else if (dst_y > YC) begin
                route = P_S;
            end else if (dst_y < YC) begin
                route = P_N;
            end
        end else begin
            if (dst_y > YC) begin
                route = P_S;
            end else if (dst_y < YC) begin
                route = P_N;
            end else if (dst_x > XC) begin
                route = P_E;
            end else if (dst_x < XC) begin
                route = P_W;
            end
        end
    end

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [4:0]    sel;
    logic [4:0]    sel_nxt;
    logic          done_nxt;
    logic          drop_nxt;

    // Packet state, remaining payload count, latched port and pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            sel      <= '0;
            pkt_done <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sel      <= sel_nxt;
            pkt_done <= done_nxt;
            drop_err <= drop_nxt;
        end
    end

    // Next-state, egress valid and head pop decisions.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        done_nxt  = 1'b0;
        drop_nxt  = 1'b0;
        pop       = 1'b0;
        e_valid   = '0;
        case (state)
            IDLE: begin
                if (h_valid) begin
                    if (legal) begin
                        e_valid = route;
                        if (|(e_ready & route)) begin
                            pop = 1'b1;
                            if (code == 4'd0) begin
                                done_nxt = 1'b1;
                            end else begin
                                cnt_nxt   = cnt_load;
                                sel_nxt   = route;
                                state_nxt = FWD;
                            end
                        end
                    end else begin
                        pop      = 1'b1;
                        drop_nxt = 1'b1;
                    end
                end
            end
            FWD: begin
                e_valid = sel & {5{h_valid}};
                if (h_valid && |(e_ready & sel)) begin
                    pop     = 1'b1;
                    cnt_nxt = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign e_dat = h_dat;
    assign busy  = (state == FWD);

endmodule

// File: tb/tb_fwnoc_router_ingress_xy.sv
// Directed bench for fwnoc_router_ingress_xy: an XY router and a YX router
// at (1,1) receive identical stimulus; handshakes are logged on the falling edge.
module tb_fwnoc_router_ingress_xy;

    logic        clock;
    logic        reset;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_dat;
    logic [4:0]  e_valid;
    logic [4:0]  e_ready;
    logic [31:0] e_dat;
    logic        busy;
    logic        pkt_done;
    logic        drop_err;

    logic        yx_i_ready;
    logic [4:0]  yx_e_valid;
    logic [31:0] yx_e_dat;
    logic        yx_busy;
    logic        yx_pkt_done;
    logic        yx_drop_err;

    int tests;
    int fails;

    fwnoc_router_ingress_xy #(
        .X_ID(1), .Y_ID(1), .ROUTE_YX(0)
    ) u_dut (
        .clock(clock), .reset(reset),
        .i_valid(i_valid), .i_ready(i_ready), .i_dat(i_dat),
        .e_valid(e_valid), .e_ready(e_ready), .e_dat(e_dat),
        .busy(busy), .pkt_done(pkt_done), .drop_err(drop_err)
    );

    fwnoc_router_ingress_xy #(
        .X_ID(1), .Y_ID(1), .ROUTE_YX(1)
    ) u_yx (
        .clock(clock), .reset(reset),
        .i_valid(i_valid), .i_ready(yx_i_ready), .i_dat(i_dat),
        .e_valid(yx_e_valid), .e_ready(e_ready), .e_dat(yx_e_dat),
        .busy(yx_busy), .pkt_done(yx_pkt_done), .drop_err(yx_drop_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] q_dat[$];
    int          q_port[$];
    int          q_cyc[$];
    int          q_yx_port[$];
    logic [31:0] q_yx_dat[$];
    int cyc, done_cyc;
    int n_done, n_drop, n_busy, n_multi, n_block;
    int n_stall, n_unstable, n_yx_diff;
    logic [4:0]  p_valid;
    logic [4:0]  p_ready;
    logic [31:0] p_dat;

    initial begin
        cyc = 0; done_cyc = 0; n_done = 0; n_drop = 0; n_busy = 0;
        n_multi = 0; n_block = 0; n_stall = 0; n_unstable = 0;
        n_yx_diff = 0; p_valid = '0; p_ready = '0; p_dat = '0;
    end

    // Falling-edge monitor: logs handshakes that complete at the next rise.
    always @(negedge clock) begin
        cyc++;
        for (int k = 0; k < 5; k++) begin
            if (e_valid[k] && e_ready[k]) begin
                q_dat.push_back(e_dat);
                q_port.push_back(k);
                q_cyc.push_back(cyc);
            end
            if (yx_e_valid[k] && e_ready[k]) begin
                q_yx_port.push_back(k);
                q_yx_dat.push_back(yx_e_dat);
            end
        end
        if (pkt_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (drop_err) n_drop++;
        if (busy) n_busy++;
        if (!$onehot0(e_valid)) n_multi++;
        if (i_valid && !i_ready) n_block++;
        if (yx_i_ready !== i_ready || yx_busy !== busy ||
            yx_pkt_done !== pkt_done || yx_drop_err !== drop_err)
            n_yx_diff++;
        if (|(p_valid & ~p_ready)) begin
            n_stall++;
            if (e_dat !== p_dat ||
                (e_valid & p_valid & ~p_ready) !== (p_valid & ~p_ready))
                n_unstable++;
        end
        p_valid = e_valid;
        p_ready = e_ready;
        p_dat   = e_dat;
    end

    task automatic send(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        i_valid = 1'b1;
        i_dat   = w;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clock);
            ok = i_ready;
            @(posedge clock);
            #1;
        end
        i_valid = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL send_accept word=%h i_ready never seen high", w);
        end
    endtask

    task automatic wait_q(input int n, input int budget);
        int c;
        c = 0;
        while (q_dat.size() < n && c < budget) begin
            @(negedge clock);
            c++;
        end
        tests++;
        if (q_dat.size() < n) begin
            fails++;
            $display("FAIL wait_words got=%0d need=%0d", q_dat.size(), n);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        tests += 5;
        if (i_ready !== 1'b0) begin
            fails++; $display("FAIL rst_i_ready got=%b exp=0", i_ready);
        end
        if (e_valid !== 5'b0) begin
            fails++; $display("FAIL rst_e_valid got=%b exp=00000", e_valid);
        end
        if (busy !== 1'b0) begin
            fails++; $display("FAIL rst_busy got=%b exp=0", busy);
        end
        if (pkt_done !== 1'b0) begin
            fails++; $display("FAIL rst_pkt_done got=%b exp=0", pkt_done);
        end
        if (drop_err !== 1'b0) begin
            fails++; $display("FAIL rst_drop_err got=%b exp=0", drop_err);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        tests++;
        if (i_ready !== 1'b1) begin
            fails++; $display("FAIL rst_release_ready got=%b exp=1", i_ready);
        end
        idle(1);
    endtask

    task automatic test_route_east;
        int b, d0, b0;
        logic [31:0] exp_w [3];
        exp_w[0] = 32'hD000_0002;
        exp_w[1] = 32'hAAAA_0001;
        exp_w[2] = 32'hBBBB_0002;
        b = q_dat.size(); d0 = n_done; b0 = n_busy;
        for (int i = 0; i < 3; i++) send(exp_w[i]);
        wait_q(b + 3, 20);
        idle(4);
        tests++;
        if (q_dat.size() != b + 3) begin
            fails++; $display("FAIL east_count got=%0d exp=3", q_dat.size() - b);
        end
        for (int i = 0; i < 3 && b + i < q_dat.size(); i++) begin
            tests += 2;
            if (q_dat[b+i] !== exp_w[i] || q_port[b+i] != 3) begin
                fails++;
                $display("FAIL east_word%0d got=%h/p%0d exp=%h/p3",
                         i, q_dat[b+i], q_port[b+i], exp_w[i]);
            end
            if (i > 0 && q_cyc[b+i] != q_cyc[b+i-1] + 1) begin
                fails++;
                $display("FAIL east_consec%0d got=%0d exp=%0d",
                         i, q_cyc[b+i], q_cyc[b+i-1] + 1);
            end
        end
        tests += 2;
        if (n_done - d0 != 1) begin
            fails++; $display("FAIL east_done got=%0d exp=1", n_done - d0);
        end
        if (n_busy - b0 != 2) begin
            fails++; $display("FAIL east_busy got=%0d exp=2", n_busy - b0);
        end
    endtask

    task automatic test_host;
        int b, d0, b0;
        b = q_dat.size(); d0 = n_done; b0 = n_busy;
        send(32'h5000_0000);
        wait_q(b + 1, 20);
        idle(3);
        tests += 4;
        if (q_dat.size() != b + 1 || q_port[b] != 0 ||
            q_dat[b] !== 32'h5000_0000) begin
            fails++;
            $display("FAIL host_word n=%0d p=%0d d=%h exp 1/p0/50000000",
                     q_dat.size() - b, q_port[b], q_dat[b]);
        end
        if (n_busy != b0) begin
            fails++; $display("FAIL host_busy got=%0d exp=0", n_busy - b0);
        end
        if (n_done - d0 != 1) begin
            fails++; $display("FAIL host_done got=%0d exp=1", n_done - d0);
        end
        if (done_cyc != q_cyc[b] + 1) begin
            fails++;
            $display("FAIL host_done_cyc got=%0d exp=%0d", done_cyc, q_cyc[b] + 1);
        end
    endtask

    task automatic test_route_yx;
        int b, by;
        b = q_dat.size(); by = q_yx_port.size();
        send(32'h0000_0000);
        wait_q(b + 1, 20);
        idle(3);
        tests += 2;
        if (q_port[b] != 4) begin
            fails++; $display("FAIL xy_west got=p%0d exp=p4", q_port[b]);
        end
        if (q_yx_port.size() != by + 1 || q_yx_port[by] != 1 ||
            q_yx_dat[by] !== 32'h0) begin
            fails++;
            $display("FAIL yx_north n=%0d p=%0d exp 1/p1",
                     q_yx_port.size() - by, q_yx_port[by]);
        end
    endtask

    task automatic test_drop;
        int b, d0, r0;
        b = q_dat.size(); d0 = n_done; r0 = n_drop;
        send(32'h4000_0007);
        send(32'h4000_0001);
        send(32'h1234_5678);
        wait_q(b + 2, 20);
        idle(4);
        tests += 4;
        if (n_drop - r0 != 1) begin
            fails++; $display("FAIL drop_pulse got=%0d exp=1", n_drop - r0);
        end
        if (q_dat.size() != b + 2) begin
            fails++; $display("FAIL drop_count got=%0d exp=2", q_dat.size() - b);
        end
        if (q_dat[b] !== 32'h4000_0001 || q_port[b] != 1 ||
            q_dat[b+1] !== 32'h1234_5678 || q_port[b+1] != 1) begin
            fails++;
            $display("FAIL drop_next_hdr got=%h/p%0d %h/p%0d exp=40000001/p1 12345678/p1",
                     q_dat[b], q_port[b], q_dat[b+1], q_port[b+1]);
        end
        if (n_done - d0 != 1) begin
            fails++; $display("FAIL drop_done got=%0d exp=1", n_done - d0);
        end
    endtask

    task automatic test_stall;
        int b, d0, k0, s0, u0;
        logic [31:0] w;
        b = q_dat.size(); d0 = n_done;
        k0 = n_block; s0 = n_stall; u0 = n_unstable;
        fork
            begin
                for (int t = 0; t < 70; t++) begin
                    @(posedge clock);
                    #1 e_ready = ~e_ready;
                end
            end
            begin
                send(32'hD000_0005);
                for (int i = 0; i < 16; i++) send(32'hC0DE_0000 + 32'(i));
            end
        join
        e_ready = 5'h1F;
        wait_q(b + 17, 60);
        idle(3);
        for (int i = 0; i < 17 && b + i < q_dat.size(); i++) begin
            w = (i == 0) ? 32'hD000_0005 : 32'hC0DE_0000 + 32'(i - 1);
            tests++;
            if (q_dat[b+i] !== w || q_port[b+i] != 3) begin
                fails++;
                $display("FAIL stall_word%0d got=%h/p%0d exp=%h/p3",
                         i, q_dat[b+i], q_port[b+i], w);
            end
        end
        tests += 5;
        if (q_dat.size() != b + 17) begin
            fails++; $display("FAIL stall_count got=%0d exp=17", q_dat.size() - b);
        end
        if (n_done - d0 != 1) begin
            fails++; $display("FAIL stall_done got=%0d exp=1", n_done - d0);
        end
        if (n_block - k0 == 0) begin
            fails++; $display("FAIL stall_full got=0 blocked cycles exp>0");
        end
        if (n_stall - s0 == 0) begin
            fails++; $display("FAIL stall_seen got=0 stalls exp>0");
        end
        if (n_unstable != u0) begin
            fails++; $display("FAIL stall_stable got=%0d exp=0", n_unstable - u0);
        end
    endtask

    task automatic test_reset_mid;
        int b, d0;
        b = q_dat.size(); d0 = n_done;
        send(32'hD000_0004);
        send(32'h0000_0011);
        send(32'h0000_0022);
        wait_q(b + 3, 20);
        @(posedge clock);
        #1 e_ready = 5'h00;
        send(32'h0000_0033);
        @(negedge clock);
        tests++;
        if (e_valid !== 5'b01000 || busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_pre got=%b/%b exp=01000/1", e_valid, busy);
        end
        #2 reset = 1'b0;
        #1;
        tests += 3;
        if (e_valid !== 5'b0) begin
            fails++; $display("FAIL mid_e_valid got=%b exp=00000", e_valid);
        end
        if (busy !== 1'b0) begin
            fails++; $display("FAIL mid_busy got=%b exp=0", busy);
        end
        if (i_ready !== 1'b0) begin
            fails++; $display("FAIL mid_i_ready got=%b exp=0", i_ready);
        end
        idle(2);
        reset = 1'b1;
        e_ready = 5'h1F;
        send(32'h0000_0000);
        wait_q(b + 4, 20);
        idle(3);
        tests += 2;
        if (q_dat.size() != b + 4 || q_port[b+3] != 4 ||
            q_dat[b+3] !== 32'h0) begin
            fails++;
            $display("FAIL mid_after n=%0d p=%0d d=%h exp 4/p4/00000000",
                     q_dat.size() - b, q_port[b+3], q_dat[b+3]);
        end
        if (n_done - d0 != 1) begin
            fails++; $display("FAIL mid_done got=%0d exp=1", n_done - d0);
        end
    endtask

    task automatic test_global;
        tests += 2;
        if (n_multi != 0) begin
            fails++; $display("FAIL onehot got=%0d bad cycles exp=0", n_multi);
        end
        if (n_yx_diff != 0) begin
            fails++; $display("FAIL xy_yx_match got=%0d cycles exp=0", n_yx_diff);
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset   = 1'b0;
        i_valid = 1'b0;
        i_dat   = '0;
        e_ready = 5'h1F;
        test_reset;
        test_route_east;
        test_host;
        test_route_yx;
        test_drop;
        test_stall;
        test_reset_mid;
        test_global;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
